// File: rtl/enc_pkg.sv
// Shared definitions for the (38,32) encoder output path: codeword/beat widths
// and the mapping from a codeword to its four 10-bit link beats.
package enc_pkg;

   localparam int CW_W  = 38;
   localparam int OUT_W = 10;
   localparam int BEATS = 4;
   localparam int PAD   = BEATS * OUT_W - CW_W;

   typedef logic [CW_W:1]    cw_t;
   typedef logic [OUT_W-1:0] beat_t;

   typedef enum logic [1:0] {
      BEAT0 = 2'd0,
      BEAT1 = 2'd1,
      BEAT2 = 2'd2,
      BEAT3 = 2'd3
   } beat_idx_t;

   // MSB goes out first; the final beat carries the last 8 bits left-justified.
   function automatic beat_t beat_of(cw_t h, beat_idx_t idx);
      beat_t b;
      case (idx)
         BEAT0:   b = h[38:29];
         BEAT1:   b = h[28:19];
         BEAT2:   b = h[18:9];
         default: b = {h[8:1], {PAD{1'b0}}};
      endcase
      return b;
   endfunction

endpackage

// File: rtl/cw_fifo.sv
// Synchronous first-word-fall-through FIFO; also exposes the entry behind the head
// so a consumer can move to the next word without a bubble.
module cw_fifo #(
   parameter int WIDTH = 38,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [WIDTH-1:0] head_next,
   output logic             full,
   output logic             empty,
   output logic             has_next
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   // A full FIFO never accepts, even if a pop happens in the same cycle.
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign has_next  = (count > CW'(1));
   assign head      = mem[rd_ptr];
   assign head_next = mem[rd_ptr + PW'(1)];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/codeword_gearbox.sv
// Buffers 38-bit codewords and emits each as four registered 10-bit beats with
// valid/ready/last framing; overflow latches any codeword offered while full.
module codeword_gearbox
   import enc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CW_W:1]    cw_in,
   input  logic             cw_valid,
   output logic             cw_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             overflow
);

   cw_t       head;
   cw_t       head_next;
   logic      full;
   logic      empty;
   logic      has_next;
   logic      pop;
   beat_idx_t beat;
   beat_idx_t beat_d;
   beat_t     data_d;
   logic      valid_d;
   logic      last_d;
   logic [1:0] beat_inc;

   cw_fifo #(
      .WIDTH(CW_W),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (cw_valid),
      .wdata    (cw_in),
      .pop      (pop),
      .head     (head),
      .head_next(head_next),
      .full     (full),
      .empty    (empty),
      .has_next (has_next)
   );

   assign cw_ready = !full;
   assign beat_inc = beat + 2'd1;

   // The head word stays in the FIFO until its last beat is accepted, so on that
   // transfer the following word (if already queued) is read from head_next.
   always_comb begin
      data_d  = out_data;
      valid_d = out_valid;
      last_d  = out_last;
      beat_d  = beat;
      pop     = 1'b0;
      if (!out_valid) begin
         if (!empty) begin
            data_d  = beat_of(head, BEAT0);
            valid_d = 1'b1;
            last_d  = 1'b0;
            beat_d  = BEAT0;
         end
      end else if (out_ready) begin
         if (beat == BEAT3) begin
            pop    = 1'b1;
            beat_d = BEAT0;
            last_d = 1'b0;
            if (has_next) begin
               data_d = beat_of(head_next, BEAT0);
            end else begin
               data_d  = '0;
               valid_d = 1'b0;
            end
         end else begin
            beat_d = beat_idx_t'(beat_inc);
            data_d = beat_of(head, beat_idx_t'(beat_inc));
            last_d = (beat_idx_t'(beat_inc) == BEAT3);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         beat      <= BEAT0;
         overflow  <= 1'b0;
      end else begin
         out_data  <= data_d;
         out_valid <= valid_d;
         out_last  <= last_d;
         beat      <= beat_d;
         if (cw_valid && full) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_codeword_gearbox.sv
// Self-checking bench for codeword_gearbox: a fixed vector table, then directed and
// random sequences checked against a queue-based model and a reassembly scoreboard.
module tb_codeword_gearbox;
   import enc_pkg::*;

   localparam int DEPTH = 4;
   localparam cw_t WA = 38'h2A_AAAA_AAAA;
   localparam cw_t WB = 38'h3F_0123_4567;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   cw_t         cw_in = '0;
   logic        cw_valid = 1'b0;
   logic        cw_ready;
   logic [9:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_last;
   logic        overflow;

   always #5 clk = ~clk;

   codeword_gearbox #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .cw_in    (cw_in),
      .cw_valid (cw_valid),
      .cw_ready (cw_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last (out_last),
      .overflow (overflow)
   );

   typedef struct {
      logic       v;
      cw_t        w;
      logic       r;
      logic       ev;
      logic [9:0] ed;
      logic       el;
      logic       ecr;
      logic       eov;
   } vec_t;

   vec_t tbl[12];

   int total = 0;
   int bad   = 0;

   // Model: accepted words not yet fully sent, with the edge at which each was pushed.
   cw_t  mq[$];
   int   mcyc[$];
   int   sent;
   int   ecount;
   bit   movf;

   cw_t        sbq[$];
   logic [9:0] asm_b[4];
   int         asm_n;
   bit         stall_prev;
   logic [9:0] prev_data;
   logic       prev_last;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [9:0] ref_beat(cw_t h, int i);
      logic [39:0] ext;
      ext = {h, 2'b00};
      return 10'(ext >> (10 * (3 - i)));
   endfunction

   function automatic cw_t rand_cw();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[37:0];
   endfunction

   function automatic bit model_valid();
      return (mq.size() > 0) && (mcyc[0] <= ecount - 1);
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      cw_valid = 1'b0;
      cw_in = '0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mq.delete();
      mcyc.delete();
      sbq.delete();
      sent = 0;
      ecount = 0;
      movf = 1'b0;
      asm_n = 0;
      stall_prev = 1'b0;
   endtask

   // Compare the outputs of the current cycle, then drive inputs for the next edge.
   task automatic apply_stimulus(input logic v, input cw_t w, input logic r);
      logic       ev;
      logic [9:0] ed;
      logic       el;
      bit         push_ok;
      cw_t        got;
      ev = model_valid();
      ed = ev ? ref_beat(mq[0], sent) : 10'h0;
      el = ev && (sent == 3);
      check_output("out_valid", out_valid, ev);
      check_output("out_data", out_data, ed);
      check_output("out_last", out_last, el);
      check_output("cw_ready", cw_ready, mq.size() < DEPTH);
      check_output("overflow", overflow, movf);
      if (stall_prev) begin
         check_output("hold_valid", out_valid, 1'b1);
         check_output("hold_data", out_data, prev_data);
         check_output("hold_last", out_last, prev_last);
      end
      if (out_valid && r) begin
         asm_b[asm_n] = out_data;
         asm_n++;
         if (asm_n == 4) begin
            asm_n = 0;
            got = {asm_b[0], asm_b[1], asm_b[2], asm_b[3][9:2]};
            if (sbq.size() == 0) begin
               check_output("sb_unexpected_word", got, 64'hDEAD);
            end else begin
               check_output("reassembly", got, sbq.pop_front());
            end
         end
      end
      if (v && cw_ready) begin
         sbq.push_back(w);
      end
      stall_prev = out_valid && !r;
      prev_data = out_data;
      prev_last = out_last;
      cw_valid = v;
      cw_in = w;
      out_ready = r;
      push_ok = v && (mq.size() < DEPTH);
      if (v && !push_ok) begin
         movf = 1'b1;
      end
      if (ev && r) begin
         sent++;
         if (sent == 4) begin
            void'(mq.pop_front());
            void'(mcyc.pop_front());
            sent = 0;
         end
      end
      if (push_ok) begin
         mq.push_back(w);
         mcyc.push_back(ecount + 1);
      end
      @(posedge clk);
      #1;
      ecount++;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         apply_stimulus(1'b0, '0, 1'b1);
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bit reached;

      // v, w, r | valid, data, last, cw_ready, overflow (checked before driving)
      tbl[0]  = '{1'b1, WA,  1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, WB,  1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, '0,  1'b1, 1'b1, 10'h2AA, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, '0,  1'b0, 1'b1, 10'h2AA, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, '0,  1'b1, 1'b1, 10'h2AA, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, '0,  1'b1, 1'b1, 10'h2AA, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, '0,  1'b1, 1'b1, 10'h2A8, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, '0,  1'b1, 1'b1, 10'h3F0, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, '0,  1'b1, 1'b1, 10'h048, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, '0,  1'b1, 1'b1, 10'h345, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, '0,  1'b1, 1'b1, 10'h19C, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{1'b0, '0,  1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0};

      do_reset();
      for (int i = 0; i < 12; i++) begin
         check_output($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
         check_output($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
         check_output($sformatf("tbl%0d_last", i), out_last, tbl[i].el);
         check_output($sformatf("tbl%0d_cw_ready", i), cw_ready, tbl[i].ecr);
         check_output($sformatf("tbl%0d_overflow", i), overflow, tbl[i].eov);
         cw_valid = tbl[i].v;
         cw_in = tbl[i].w;
         out_ready = tbl[i].r;
         @(posedge clk);
         #1;
      end

      $display("[TB] encoder-rate stream");
      do_reset();
      for (int c = 0; c < 64; c++) begin
         apply_stimulus(c % 4 == 0, rand_cw(), 1'b1);
      end
      drain(8);
      check_output("rate_overflow", overflow, 1'b0);

      $display("[TB] backpressure fill");
      do_reset();
      for (int k = 0; k < 5; k++) begin
         apply_stimulus(1'b1, rand_cw(), 1'b0);
      end
      check_output("bp_overflow", overflow, 1'b1);
      check_output("bp_cw_ready", cw_ready, 1'b0);
      drain(24);
      check_output("bp_drained", sbq.size(), 0);

      $display("[TB] random backpressure");
      do_reset();
      for (int c = 0; c < 400; c++) begin
         apply_stimulus($urandom_range(0, 2) == 0, rand_cw(), 1'($urandom_range(0, 1)));
      end
      drain(40);
      check_output("rand_drained", sbq.size(), 0);

      $display("[TB] reset mid-codeword");
      do_reset();
      apply_stimulus(1'b1, rand_cw(), 1'b1);
      apply_stimulus(1'b1, rand_cw(), 1'b1);
      reached = 1'b0;
      for (int i = 0; i < 10 && !reached; i++) begin
         if (model_valid() && sent == 2 && mq.size() == 2) begin
            reached = 1'b1;
         end else begin
            apply_stimulus(1'b0, '0, 1'b1);
         end
      end
      check_output("rst_reached_beat2", reached, 1'b1);
      do_reset();
      check_output("rst_out_valid", out_valid, 1'b0);
      check_output("rst_cw_ready", cw_ready, 1'b1);
      apply_stimulus(1'b0, '0, 1'b1);
      apply_stimulus(1'b1, WB, 1'b1);
      apply_stimulus(1'b0, '0, 1'b1);
      check_output("rst_restart_b0", out_data, 10'h3F0);
      drain(8);

      $display("[TB] push during beat-3 pop while full");
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b1, rand_cw(), 1'b0);
      end
      reached = 1'b0;
      for (int i = 0; i < 10 && !reached; i++) begin
         if (model_valid() && sent == 3 && mq.size() == 4) begin
            reached = 1'b1;
         end else begin
            apply_stimulus(1'b0, '0, 1'b1);
         end
      end
      check_output("full_reached_beat3", reached, 1'b1);
      check_output("full_cw_ready", cw_ready, 1'b0);
      apply_stimulus(1'b1, rand_cw(), 1'b1);
      check_output("full_drop_overflow", overflow, 1'b1);
      check_output("full_after_pop_ready", cw_ready, 1'b1);
      check_output("full_occupancy", mq.size(), DEPTH - 1);
      apply_stimulus(1'b0, '0, 1'b0);
      drain(20);
      check_output("full_drained", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
